// File: rtl/mc_mem_pkg.sv
// Shared definitions for the multicycle-MIPS memory responder.
// Holds the controller state encoding, byte-lane select constants, the
// wait-state counter width and small lane helper functions used by the
// responder and its storage array.
package mc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int CNT_W = 4;

    // Byte lanes inside a 32-bit word, little-endian (lane 0 = bits 7:0).
    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    // Lane write-enable mask: all lanes for a word, one lane for a byte.
    function automatic logic [3:0] lane_mask(input logic byte_sel, input logic [1:0] lane);
        logic [3:0] m;
        if (byte_sel) begin
            case (lane)
                LANE0:   m = 4'b0001;
                LANE1:   m = 4'b0010;
                LANE2:   m = 4'b0100;
                LANE3:   m = 4'b1000;
                default: m = 4'b0000;
            endcase
        end else begin
            m = 4'b1111;
        end
        return m;
    endfunction

    // Select one byte lane of a word and sign-extend it to 32 bits.
    function automatic logic [31:0] lane_sext(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            LANE0:   b = word[7:0];
            LANE1:   b = word[15:8];
            LANE2:   b = word[23:16];
            LANE3:   b = word[31:24];
            default: b = 8'h00;
        endcase
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mc_mem_array.sv
// Unified word-organised storage for the memory responder.
// Ports:
//   clk      - clock, all updates on the rising edge
//   idx      - word index shared by read and write
//   rd_en    - capture mem[idx] into the read register
//   lane_we  - per-byte-lane write enables (bit n writes bits 8n+7:8n)
//   wdata    - write data, lane n taken from wdata[8n+7:8n]
//   rdata    - registered read data
// Storage has no reset: contents survive a responder reset.
module mc_mem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] idx,
    input  logic              rd_en,
    input  logic [3:0]        lane_we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [0:(1<<ADDR_W)-1];
    logic [31:0] rdata_q;

    // Byte-lane write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (lane_we[l]) begin
                mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
        if (rd_en) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mc_mem_responder.sv
// Memory-side responder for the multicycle MIPS datapath.
// Serves fetch/lw/sw (word) and lb/sb (byte) requests with WAIT_CYCLES
// wait states, reporting completion with a one-cycle ready pulse.
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   req              - request strobe, sampled only in IDLE
//   we, byte_sel     - write / byte-access qualifiers
//   addr, wdata      - byte address and write data (sb uses wdata[7:0])
//   rdata, ready, err- registered response, valid while ready=1
module mc_mem_responder
    import mc_mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                byte_q, byte_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                fault_s;
    logic [ADDR_W-1:0]   idx_s;
    logic                rd_en_s;
    logic [3:0]          lane_we_s;
    logic [31:0]         arr_wdata_s;
    logic [31:0]         arr_rdata_s;

    // Misaligned word access or address beyond the array is a fault.
    assign fault_s = ((byte_sel == 1'b0) && (addr[1:0] != 2'b00)) ||
                     (addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});

    // With zero wait states ACCESS follows IDLE directly, so the array must
    // be addressed from the live inputs in IDLE and from the latch otherwise.
    assign idx_s       = (state_q == IDLE) ? addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
    assign rd_en_s     = (state_d == ACCESS) && !reset;
    assign lane_we_s   = (state_q == ACCESS && we_q && !reset) ? lane_mask(byte_q, addr_q[1:0])
                                                               : 4'b0000;
    assign arr_wdata_s = byte_q ? {4{wdata_q[7:0]}} : wdata_q;

    mc_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .idx     (idx_s),
        .rd_en   (rd_en_s),
        .lane_we (lane_we_s),
        .wdata   (arr_wdata_s),
        .rdata   (arr_rdata_s)
    );

    // Next-state, request latching and response formation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    byte_d  = byte_sel;
                    addr_d  = addr[ADDR_W+1:0];
                    wdata_d = wdata;
                    if (fault_s) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0000_0000;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        cnt_d   = WAIT_LD;
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    rdata_d = byte_q ? lane_sext(arr_rdata_s, addr_q[1:0]) : arr_rdata_s;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == RESP);
    end

    // State, latched request and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= {(ADDR_W+2){1'b0}};
            wdata_q <= 32'h0000_0000;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed self-checking bench for mc_mem_responder.
// Instance a uses WAIT_CYCLES=2, instance b uses WAIT_CYCLES=0.
module tb_mc_mem_responder;

    logic clk = 1'b0;
    logic reset;
    logic req_a, we_a, bs_a, req_b, we_b, bs_b;
    logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
    logic [31:0] rdata_a, rdata_b;
    logic ready_a, err_a, ready_b, err_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .byte_sel(bs_a),
        .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .err(err_a)
    );

    mc_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .byte_sel(bs_b),
        .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; lat counts cycles from the req-sampling edge.
    task automatic do_txn(input bit b, input bit w, input bit bsel,
                          input logic [31:0] a, input logic [31:0] d, input bit corrupt,
                          output int lat, output logic [31:0] rd, output logic er);
        logic rdy;
        @(negedge clk);
        if (b) begin req_b = 1'b1; we_b = w; bs_b = bsel; addr_b = a; wdata_b = d; end
        else   begin req_a = 1'b1; we_a = w; bs_a = bsel; addr_a = a; wdata_a = d; end
        @(posedge clk);
        lat = 1;
        #1;
        if (corrupt) begin
            addr_a  = a ^ 32'h0000_0004;
            wdata_a = ~d;
        end
        rdy = b ? ready_b : ready_a;
        while (!rdy && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            rdy = b ? ready_b : ready_a;
        end
        if (!rdy) lat = 99;
        rd = b ? rdata_b : rdata_a;
        er = b ? err_b : err_a;
        req_a = 1'b0;
        req_b = 1'b0;
        @(posedge clk); #1;
        rdy = b ? ready_b : ready_a;
        chk("ready_one_pulse", {31'd0, rdy}, 32'd0);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          pulses, first_c, second_c;
    logic [31:0] b2b_rd;

    initial begin
        reset = 1'b1;
        req_a = 1'b0; we_a = 1'b0; bs_a = 1'b0; addr_a = 32'd0; wdata_a = 32'd0;
        req_b = 1'b0; we_b = 1'b0; bs_b = 1'b0; addr_b = 32'd0; wdata_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready_a}, 32'd0);
        chk("rst_err",   {31'd0, err_a},   32'd0);
        chk("rst_rdata", rdata_a,          32'd0);
        @(negedge clk);
        reset = 1'b0;

        // word write then read
        do_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, lat, rd, er);
        chk("sw_lat", lat, 32'd4);
        chk("sw_err", {31'd0, er}, 32'd0);
        do_txn(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er);
        chk("lw_lat",   lat, 32'd4);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err",   {31'd0, er}, 32'd0);

        // byte write and sign-extended byte reads
        do_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h11223344, 1'b0, lat, rd, er);
        do_txn(1'b0, 1'b1, 1'b1, 32'h13, 32'h000000F0, 1'b0, lat, rd, er);
        chk("sb_lat", lat, 32'd4);
        do_txn(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er);
        chk("lw_after_sb", rd, 32'hF0223344);
        do_txn(1'b0, 1'b0, 1'b1, 32'h13, 32'h0, 1'b0, lat, rd, er);
        chk("lb_13", rd, 32'hFFFFFFF0);
        do_txn(1'b0, 1'b0, 1'b1, 32'h12, 32'h0, 1'b0, lat, rd, er);
        chk("lb_12", rd, 32'h00000022);

        // faults: misaligned word and out-of-range address
        do_txn(1'b0, 1'b0, 1'b0, 32'h12, 32'h0, 1'b0, lat, rd, er);
        chk("flt_mis_lat",   lat, 32'd1);
        chk("flt_mis_err",   {31'd0, er}, 32'd1);
        chk("flt_mis_rdata", rd, 32'd0);
        do_txn(1'b0, 1'b1, 1'b0, 32'h00001000, 32'h55AA55AA, 1'b0, lat, rd, er);
        chk("flt_oor_lat", lat, 32'd1);
        chk("flt_oor_err", {31'd0, er}, 32'd1);
        do_txn(1'b0, 1'b1, 1'b0, 32'h12, 32'h99999999, 1'b0, lat, rd, er);
        chk("flt_sw_err", {31'd0, er}, 32'd1);
        do_txn(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, lat, rd, er);
        chk("flt_oor_nowrite", rd, 32'd0);
        do_txn(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er);
        chk("flt_mis_nowrite", rd, 32'hF0223344);

        // reset during WAIT aborts a store (rdata currently nonzero)
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; bs_a = 1'b0; addr_a = 32'h20; wdata_a = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        req_a = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ready", {31'd0, ready_a}, 32'd0);
        chk("mid_rst_err",   {31'd0, err_a},   32'd0);
        chk("mid_rst_rdata", rdata_a,          32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_txn(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, lat, rd, er);
        chk("mid_rst_nowrite", rd, 32'd0);

        // zero wait states
        do_txn(1'b1, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0, lat, rd, er);
        chk("w0_sw_lat", lat, 32'd2);
        do_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, lat, rd, er);
        chk("w0_lw_lat",   lat, 32'd2);
        chk("w0_lw_rdata", rd, 32'hCAFEF00D);

        // back-to-back: sw then lw with req held high through RESP
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; bs_a = 1'b0; addr_a = 32'h50; wdata_a = 32'h0BADC0DE;
        @(posedge clk);
        pulses = 0; first_c = 0; second_c = 0; b2b_rd = 32'd0;
        for (int i = 1; i <= 16; i++) begin
            #1;
            if (ready_a) begin
                pulses++;
                if (pulses == 1) begin
                    first_c = i;
                    we_a = 1'b0; wdata_a = 32'hFFFFFFFF;
                end else begin
                    second_c = i;
                    b2b_rd = rdata_a;
                    req_a = 1'b0;
                end
            end
            @(posedge clk);
        end
        chk("b2b_pulses", pulses,   32'd2);
        chk("b2b_first",  first_c,  32'd4);
        chk("b2b_second", second_c, 32'd9);
        chk("b2b_rdata",  b2b_rd,   32'h0BADC0DE);

        // inputs changed while busy must be ignored
        do_txn(1'b0, 1'b1, 1'b0, 32'h60, 32'hAAAA5555, 1'b1, lat, rd, er);
        chk("stab_lat", lat, 32'd4);
        do_txn(1'b0, 1'b0, 1'b0, 32'h60, 32'h0, 1'b0, lat, rd, er);
        chk("stab_orig", rd, 32'hAAAA5555);
        do_txn(1'b0, 1'b0, 1'b0, 32'h64, 32'h0, 1'b0, lat, rd, er);
        chk("stab_other", rd, 32'h00000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
